uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx byte transmitter between N requesters, using round-robin arbitration.

---
 rtl/uart_tx_arbiter_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 tb/tb_uart_tx_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encodings, UART divider constant and a clog2 helper
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;
  localparam int UART_DIV = 434;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotate-priority encoder, first set req bit at or after ptr (mod N)
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  int k;
  assign valid = |req;
  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    idx = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) idx = W'(k);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N requesters,
// with per-owner frame lock bounded by MAX_BURST and a TX_BUSY rise timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N            = 4,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 8,
  localparam int W = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic           idle,
  output logic           err
);
  state_t state, state_nx;
  logic [W-1:0] rr_ptr, owner, pick, win;
  logic pick_v, locked, keep, timeout;
  logic [7:0] burst_cnt, burst_nx, to_cnt;
  uart_rr_pick #(.N(N)) u_pick (.req(req), .ptr(rr_ptr), .idx(pick), .valid(pick_v));
  always_comb begin
    win = (locked && req[owner]) ? owner : pick;
    burst_nx = locked ? burst_cnt + 8'd1 : 8'd1;
    keep = lock[owner] && burst_nx < 8'(MAX_BURST);
    timeout = to_cnt == 8'(BUSY_TIMEOUT - 1);
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = (pick_v && !tx_busy) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:     state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_nx = tx_busy ? ST_WAIT_DONE : timeout ? ST_IDLE : ST_WAIT_BUSY;
      default:      state_nx = tx_busy ? ST_WAIT_DONE : ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idle      <= 1'b1;
      ack       <= '0;
      grant     <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      err       <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      locked    <= 1'b0;
      burst_cnt <= 8'd0;
      to_cnt    <= 8'd0;
    end else begin
      state    <= state_nx;
      idle     <= state_nx == ST_IDLE;
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A lock lapses as soon as its owner stops requesting.
          if (!req[owner]) locked <= 1'b0;
          if (pick_v && !tx_busy) begin
            owner    <= win;
            grant    <= N'(1) << win;
            ack      <= N'(1) << win;
            tx_start <= 1'b1;
            tx_data  <= req_data[{win, 3'b000} +: 8];
          end
        end
        ST_ISSUE: to_cnt <= 8'd0;
        ST_WAIT_BUSY: begin
          if (!tx_busy && timeout) begin
            err    <= 1'b1;
            grant  <= '0;
            locked <= 1'b0;
          end else if (!tx_busy) to_cnt <= to_cnt + 8'd1;
        end
        default: begin
          if (!tx_busy) begin
            grant     <= '0;
            locked    <= keep;
            burst_cnt <= keep ? burst_nx : 8'd0;
            if (!keep) rr_ptr <= owner == W'(N - 1) ? '0 : owner + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with an inline divide-by-4 uart_tx model (40-cycle frame).
module tb_uart_tx_arbiter;
  logic clk = 0, rst_n = 0;
  logic [3:0] req = 0, lock = 0;
  logic [31:0] req_data = 0;
  logic [3:0] ack, grant;
  logic tx_start, tx_busy, idle, err;
  logic [7:0] tx_data;
  logic stub = 0, u_busy = 0, line;
  logic [9:0] sh = '1, cap = 0;
  logic [5:0] cyc = 0;
  logic [3:0] ack_q[$];
  logic [7:0] dat_q[$];
  int n_start = 0, n_viol = 0, n_chk = 0, n_pass = 0;
  localparam logic [3:0] EXP2[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [3:0] EXP3[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N(4), .MAX_BURST(3), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_data(req_data),
    .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .idle(idle), .err(err)
  );
  assign tx_busy = u_busy & ~stub;
  assign line = sh[0];
  always @(posedge clk) begin
    if (!u_busy) begin
      if (tx_start && !stub) begin
        u_busy <= 1'b1;
        sh <= {1'b1, tx_data, 1'b0};
        cyc <= '0;
      end
    end else begin
      cyc <= cyc + 6'd1;
      if (cyc[1:0] == 2'd3) sh <= {1'b1, sh[9:1]};
      if (cyc == 6'd39) u_busy <= 1'b0;
    end
  end
  always @(negedge clk) begin
    if (ack != 0) ack_q.push_back(ack);
    if (tx_start) begin
      n_start++;
      dat_q.push_back(tx_data);
      if (u_busy) n_viol++;
    end
    if (u_busy && cyc[1:0] == 2'd1) cap <= {line, cap[9:1]};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    req = 0;
    lock = 0;
    rst_n = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    ack_q.delete();
    dat_q.delete();
    n_start = 0;
    n_viol = 0;
  endtask
  task automatic wait_acks(input int n, input int max, input string tag);
    for (int i = 0; i < max && ack_q.size() < n; i++) step();
    chk(tag, ack_q.size(), n);
  endtask
  task automatic wait_idle(input int max, input string tag);
    for (int i = 0; i < max && !idle; i++) step();
    chk(tag, idle, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_grant", grant, 4'b0100);
    req = 0;
    step();
    chk("t1_start_pulse", tx_start, 0);
    wait_idle(100, "t1_idle");
    chk("t1_line", cap, 10'h34A);
    chk("t1_grant_clr", grant, 0);
    do_reset();
    req_data = 32'h13121110;
    req = 4'hF;
    wait_acks(5, 400, "t2_nack");
    req = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_ack%0d", i), ack_q[i], EXP2[i]);
      chk($sformatf("t2_dat%0d", i), dat_q[i], 8'h10 + 8'(i % 4));
    end
    chk("t2_start_while_busy", n_viol, 0);
    wait_idle(100, "t2_idle");
    do_reset();
    req = 4'b1010;
    lock = 4'b0010;
    wait_acks(5, 400, "t3_nack");
    req = 0;
    lock = 0;
    for (int i = 0; i < 5; i++) chk($sformatf("t3_ack%0d", i), ack_q[i], EXP3[i]);
    wait_idle(100, "t3_idle");
    do_reset();
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    wait_acks(1, 20, "t4_nack");
    req = 0;
    repeat (15) step();
    req = 4'b0001;
    step();
    req = 0;
    wait_idle(100, "t4_idle");
    repeat (5) step();
    chk("t4_acks", ack_q.size(), 1);
    chk("t4_starts", n_start, 1);
    do_reset();
    stub = 1;
    req = 4'b0001;
    wait_acks(1, 20, "t5_nack");
    req = 0;
    repeat (8) step();
    chk("t5_err_early", err, 0);
    chk("t5_grant_held", grant, 4'b0001);
    chk("t5_idle_early", idle, 0);
    step();
    chk("t5_err", err, 1);
    chk("t5_idle", idle, 1);
    chk("t5_grant", grant, 0);
    repeat (20) step();
    chk("t5_err_sticky", err, 1);
    chk("t5_starts", n_start, 1);
    stub = 0;
    do_reset();
    chk("t5_err_rst", err, 0);
    req_data[31:24] = 8'h3C;
    req = 4'b1000;
    wait_acks(1, 20, "t6_nack");
    req_data[31:24] = 8'h3D;
    repeat (10) step();
    rst_n = 0;
    step();
    chk("t6_grant", grant, 0);
    chk("t6_start", tx_start, 0);
    chk("t6_data", tx_data, 8'h00);
    chk("t6_idle", idle, 1);
    repeat (2) step();
    rst_n = 1;
    for (int i = 0; i < 60 && u_busy; i++) step();
    chk("t6_no_start_busy", n_start, 1);
    wait_acks(2, 20, "t6_nack2");
    chk("t6_ack", ack_q[1], 4'b1000);
    chk("t6_dat", dat_q[1], 8'h3D);
    chk("t6_viol", n_viol, 0);
    req = 0;
    wait_idle(100, "t6_idle_end");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
